clock_stop_ctrl: RTL

// - Power-down counterpart of the power-up clock delay: on request, drains for STOP_DLY cycles, then glitch-free gates clk_out off.
// - On request release, holds clk_out off for START_DLY cycles, then re-enables it.
// - Sits between the board clock and the downstream chip clock pin; the power controller drives the stop_req/stop_ack handshake.

---
 rtl/clock_stop_ctrl_pkg.sv | 17 +
 rtl/clock_stop_ctrl_gate_cell.sv | 20 ++
 rtl/clock_stop_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/clock_stop_ctrl_pkg.sv
// Shared constants for the clock stop/start controller.
// Defines state encodings, default delays and the stop-event counter width.
package clock_stop_ctrl_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  // 50 MHz source: 1 us drain, 1 s wake hold-off
  localparam int DEF_STOP_DLY  = 50;
  localparam int DEF_START_DLY = 50_000_000;
  localparam int DEF_CNT_W     = 26;

  localparam int STOP_CNT_W = 16;

endpackage

// File: rtl/clock_stop_ctrl_gate_cell.sv
// Glitch-free clock gate: enable captured on the falling edge so it
// only changes while the source clock is low, then ANDed with it.
module clk_gate_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic gate_en_n;

  // enable retimed on negedge; async clear forces the output low at once
  always_ff @(negedge clk or posedge rst) begin
    if (rst) gate_en_n <= 1'b0;
    else     gate_en_n <= en;
  end

  assign gclk = clk & gate_en_n;

endmodule

// File: rtl/clock_stop_ctrl.sv
// Clock stop controller: drains then gates clk_out on stop_req, and
// holds it off for START_DLY cycles on release. Option: CLKSTOP_CNT_EN.
module clock_stop_ctrl
  import clock_stop_ctrl_pkg::*;
#(
  parameter int STOP_DLY  = DEF_STOP_DLY,
  parameter int START_DLY = DEF_START_DLY,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk_in,
  input  logic rst,
  input  logic stop_req,
  output logic stop_ack,
  output logic clk_out,
  output logic clk_on
`ifdef CLKSTOP_CNT_EN
  ,
  output logic [STOP_CNT_W-1:0] stop_cnt
`endif
);

  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_DLY - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ack_d;
  logic             on_d;
`ifdef CLKSTOP_CNT_EN
  logic             stop_done;
`endif

  // next-state, counter and handshake decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ack_d   = stop_ack;
    on_d    = clk_on;
`ifdef CLKSTOP_CNT_EN
    stop_done = 1'b0;
`endif
    unique case (state)
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (!stop_req) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt == STOP_LAST) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          ack_d   = 1'b1;
          on_d    = 1'b0;
`ifdef CLKSTOP_CNT_EN
          stop_done = 1'b1;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (!stop_req) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // a new request during wake drops straight back to OFF
        if (stop_req) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt == START_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          ack_d   = 1'b0;
          on_d    = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_WAKE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and status registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= ST_WAKE;
      cnt      <= '0;
      stop_ack <= 1'b1;
      clk_on   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      stop_ack <= ack_d;
      clk_on   <= on_d;
    end
  end

`ifdef CLKSTOP_CNT_EN
  // completed stop events, wrapping at the counter width
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)            stop_cnt <= '0;
    else if (stop_done) stop_cnt <= stop_cnt + 1'b1;
  end
`endif

  clk_gate_cell u_gate (
    .clk  (clk_in),
    .rst  (rst),
    .en   (clk_on),
    .gclk (clk_out)
  );

endmodule
